mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter that shares one synchronous data memory between the

---
 rtl/mem_arbiter.sv | 93 +++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one synchronous memory, one transaction outstanding
// Ports:
//   i_clk, i_rst                        clock (rising edge), asynchronous active-high reset
//   i_req0_valid/addr, req0_ready       port0 fetch request (read only)
//   rsp0_valid, rsp0_rdata              port0 response pulse and held read data
//   i_req1_valid/addr/we/wdata/wstrb    port1 load/store request
//   req1_ready, rsp1_valid, rsp1_rdata  port1 handshake, response pulse and held read data
//   mem_en/we/addr/wdata/wstrb          memory strobe, driven only in the handshake cycle
//   i_mem_rdata                         memory read data, valid MEM_LAT cycles after mem_en
//   busy, owner                         transaction outstanding, port of current/last grant
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0_valid,
  input  logic [ADDR_W-1:0]   i_req0_addr,
  output logic                req0_ready,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  input  logic                i_req1_valid,
  input  logic [ADDR_W-1:0]   i_req1_addr,
  input  logic                i_req1_we,
  input  logic [DATA_W-1:0]   i_req1_wdata,
  input  logic [DATA_W/8-1:0] i_req1_wstrb,
  output logic                req1_ready,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                busy,
  output logic                owner
);
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..4");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data
    $error("mem_arbiter: DATA_W must be a multiple of 8");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);
  state_t state, state_nx;
  logic [1:0] lat_cnt;
  logic last_grant, wr, win, hs, last_wait;
  always_comb begin
    // on a tie the port that did not win last time goes first
    win = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
    // reset gates the handshake so every output is 0 while i_rst is high
    hs = !i_rst && (i_req0_valid || i_req1_valid) && (state == S_IDLE || state == S_RESP);
    last_wait = state == S_WAIT && lat_cnt == 2'd0;
    state_nx = hs ? S_WAIT : (state == S_WAIT ? (last_wait ? S_RESP : S_WAIT) : S_IDLE);
    req0_ready = hs && !win;
    req1_ready = hs && win;
    mem_en = hs;
    mem_we = hs && win && i_req1_we;
    mem_addr = hs ? (win ? i_req1_addr : i_req0_addr) : '0;
    mem_wdata = (hs && win) ? i_req1_wdata : '0;
    mem_wstrb = (hs && win) ? i_req1_wstrb : '0;
    rsp0_valid = state == S_RESP && !owner;
    rsp1_valid = state == S_RESP && owner;
    busy = state != S_IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_cnt <= 2'd0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      wr <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (hs) begin
        owner <= win;
        last_grant <= win;
        wr <= win && i_req1_we;
        lat_cnt <= LAT_INIT;
      end else if (state == S_WAIT && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (last_wait && owner) rsp1_rdata <= wr ? '0 : i_mem_rdata;
      if (last_wait && !owner) rsp0_rdata <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, we1 = 1'b0, v3_1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, wd1 = '0;
  logic [3:0] ws1 = '0;
  logic r0, r1, s0_v, s1_v, m_en, m_we, bsy, own;
  logic [31:0] s0_d, s1_d, m_addr, m_wd, m_rd;
  logic [3:0] m_ws;
  logic r0_3, r1_3, s0_v3, s1_v3, m_en3, m_we3, bsy3, own3;
  logic [31:0] s0_d3, s1_d3, m_addr3, m_wd3, m_rd3;
  logic [3:0] m_ws3;
  logic [31:0] d1, q1, q2, q3;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) u1 (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_addr(a0), .req0_ready(r0), .rsp0_valid(s0_v), .rsp0_rdata(s0_d),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_we(we1), .i_req1_wdata(wd1), .i_req1_wstrb(ws1),
    .req1_ready(r1), .rsp1_valid(s1_v), .rsp1_rdata(s1_d),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wd), .mem_wstrb(m_ws),
    .i_mem_rdata(m_rd), .busy(bsy), .owner(own)
  );

  mem_arbiter #(.MEM_LAT(3)) u3 (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(1'b0), .i_req0_addr(a0), .req0_ready(r0_3), .rsp0_valid(s0_v3), .rsp0_rdata(s0_d3),
    .i_req1_valid(v3_1), .i_req1_addr(a1), .i_req1_we(we1), .i_req1_wdata(wd1), .i_req1_wstrb(ws1),
    .req1_ready(r1_3), .rsp1_valid(s1_v3), .rsp1_rdata(s1_d3),
    .mem_en(m_en3), .mem_we(m_we3), .mem_addr(m_addr3), .mem_wdata(m_wd3), .mem_wstrb(m_ws3),
    .i_mem_rdata(m_rd3), .busy(bsy3), .owner(own3)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'd1337 : {a[15:0], 16'hC0DE};
  endfunction

  // memory models: data is present only in the cycle exactly MEM_LAT after mem_en; writes return junk
  always @(posedge clk) d1 <= m_en ? (m_we ? 32'hFFFF_FFFF : memf(m_addr)) : 32'h0BAD_0BAD;
  always @(posedge clk) begin
    q1 <= m_en3 ? (m_we3 ? 32'hFFFF_FFFF : memf(m_addr3)) : 32'h0BAD_0BAD;
    q2 <= q1;
    q3 <= q2;
  end
  assign m_rd = d1;
  assign m_rd3 = q3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_rdy, exp_rsp;
    v0 = 1'b1;
    v1 = 1'b1;
    #3;
    chk("rst_ready", {r1, r0}, 2'b00);
    chk("rst_mem_en", m_en, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_owner", own, 0);
    chk("rst_rdata", {s0_d, s1_d}, 0);
    tick;
    tick;
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    tick;
    // port0 read of 0x10
    tick;
    v0 = 1'b1; a0 = 32'h10;
    #1;
    chk("t1_ready", {r1, r0}, 2'b01);
    chk("t1_mem_en", m_en, 1);
    chk("t1_mem_addr", m_addr, 32'h10);
    chk("t1_mem_we", {m_we, m_ws}, 0);
    tick;
    v0 = 1'b0;
    #1;
    chk("t1_wait_busy", bsy, 1);
    chk("t1_wait_rsp", {s1_v, s0_v, m_en}, 0);
    tick;
    #1;
    chk("t1_rsp", {s1_v, s0_v}, 2'b01);
    chk("t1_rdata", s0_d, 32'd1337);
    tick;
    #1;
    chk("t1_after", {s0_v, bsy}, 0);
    chk("t1_hold", s0_d, 32'd1337);
    // port1 write
    tick;
    v1 = 1'b1; a1 = 32'h20; we1 = 1'b1; wd1 = 32'hDEADBEEF; ws1 = 4'b0011;
    #1;
    chk("t3_ready", {r1, r0}, 2'b10);
    chk("t3_mem_we", {m_en, m_we}, 2'b11);
    chk("t3_wstrb", m_ws, 4'b0011);
    chk("t3_wdata", m_wd, 32'hDEADBEEF);
    chk("t3_addr", m_addr, 32'h20);
    tick;
    v1 = 1'b0; we1 = 1'b0; ws1 = 4'b0; wd1 = 32'h0;
    #1;
    chk("t3_wait_rsp", {s1_v, s0_v}, 0);
    tick;
    #1;
    chk("t3_rsp", {s1_v, s0_v}, 2'b10);
    chk("t3_rdata", s1_d, 0);
    chk("t3_other_rdata", s0_d, 32'd1337);
    tick;
    // continuous demand on both ports: grants alternate starting with port0
    for (int c = 0; c < 5; c++) begin
      tick;
      if (c == 0) begin
        v0 = 1'b1; a0 = 32'h40; v1 = 1'b1; a1 = 32'h44;
      end
      #1;
      exp_rdy = (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (c == 2) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      chk($sformatf("t2_ready_c%0d", c), {r1, r0}, exp_rdy);
      chk($sformatf("t2_rsp_c%0d", c), {s1_v, s0_v}, exp_rsp);
      if (c == 2) chk("t2_rdata0", s0_d, memf(32'h40));
      if (c == 4) chk("t2_rdata1", s1_d, memf(32'h44));
      if (exp_rdy != 2'b00) chk($sformatf("t2_addr_c%0d", c), m_addr, exp_rdy[1] ? 32'h44 : 32'h40);
    end
    tick;
    v0 = 1'b0; v1 = 1'b0;
    #1;
    chk("t2_wait_ready", {r1, r0}, 0);
    tick;
    #1;
    chk("t2_last_rsp", {s1_v, s0_v, r1, r0}, 4'b0100);
    chk("t2_last_rdata", s0_d, memf(32'h40));
    tick;
    #1;
    chk("t2_idle", bsy, 0);
    // reset during WAIT of a port0 read; afterwards port0 must win the tie again
    tick;
    v0 = 1'b1; a0 = 32'h10;
    #1;
    chk("t5_ready", {r1, r0}, 2'b01);
    tick;
    v0 = 1'b0;
    #1;
    chk("t5_busy_pre", bsy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {bsy, own, s0_v, s1_v, m_en, r0, r1}, 0);
    chk("t5_rst_rdata", {s0_d, s1_d}, 0);
    tick;
    #1;
    chk("t5_no_rsp", {s1_v, s0_v, bsy}, 0);
    tick;
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = 32'h50; a1 = 32'h54;
    #1;
    chk("t5_first_grant", {r1, r0}, 2'b01);
    tick;
    v0 = 1'b0; v1 = 1'b0;
    tick;
    #1;
    chk("t5_rsp", {s1_v, s0_v}, 2'b01);
    chk("t5_rdata", s0_d, memf(32'h50));
    tick;
    // port0 valid only during port1's WAIT: nothing is accepted
    tick;
    v1 = 1'b1; a1 = 32'h60;
    #1;
    chk("t6_ready1", {r1, r0}, 2'b10);
    tick;
    v1 = 1'b0; v0 = 1'b1; a0 = 32'h70;
    #1;
    chk("t6_wait_block", {r0, m_en}, 0);
    tick;
    v0 = 1'b0;
    #1;
    chk("t6_resp_no_grant", {r0, m_en}, 0);
    chk("t6_rsp1", {s1_v, s0_v}, 2'b10);
    chk("t6_rdata1", s1_d, memf(32'h60));
    tick;
    #1;
    chk("t6_idle", {bsy, m_en}, 0);
    // MEM_LAT=3 instance: busy for four cycles, response in the fourth only
    tick;
    v3_1 = 1'b1; a1 = 32'h80;
    #1;
    chk("t4_ready", {r1_3, m_en3}, 2'b11);
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i == 1) v3_1 = 1'b0;
      #1;
      chk($sformatf("t4_busy_%0d", i), bsy3, (i <= 4) ? 1 : 0);
      chk($sformatf("t4_rsp_%0d", i), {s1_v3, s0_v3}, (i == 4) ? 2'b10 : 2'b00);
      if (i == 4) chk("t4_rdata", s1_d3, memf(32'h80));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
